// File: rtl/tinyspu_io_pkg.sv
// Shared definitions for the TinySPU pin front end.
//   nb_of()      : number of bytes in a DATA_W-bit word
//   uio indices  : bit positions of the host strobes and status flags on uio
//   UIO_OE_VAL   : fixed output-enable pattern for the bidirectional pins
//   ser_state_e  : result serialiser states
package tinyspu_io_pkg;

  localparam int IN_STB  = 0;
  localparam int OUT_STB = 1;
  localparam int OUT_ACK = 2;
  localparam int FULL    = 3;
  localparam int EMPTY   = 4;
  localparam int OVF     = 5;
  localparam int LPBK    = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'h3A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ACKLO = 2'd2
  } ser_state_e;

  function automatic int nb_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/tinyspu_sync_fifo.sv
// First-word fall-through command FIFO.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write wdata_i (dropped and overflow_o set if full without a pop)
//   wdata_i      : word to write
//   pop_i        : discard the head word (ignored while empty)
//   rdata_o      : head word, valid whenever empty_o is low
//   full_o       : DEPTH words held
//   empty_o      : no words held
//   overflow_o   : sticky, a push was dropped since reset
module tinyspu_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FULL_CNT);
  assign overflow_o = ovf_q;
  assign rdata_o    = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when the head is leaving.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_i && !do_push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: it is only visible through rdata_o when not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tinyspu_pin_frontend.sv
// Byte-serial pin front end between the Tiny Tapeout pins and the SPU core.
// Host bytes on ui_in are packed LSB first into DATA_W-bit command words and
// queued in a FWFT FIFO; core results are shown a byte at a time on uo_out
// under an out_stb/out_ack four-phase handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ena                 : design selected; when low all state holds
//   ui_in               : host command byte
//   uio_in              : [0] in_stb, [2] out_ack, [7] loopback select
//   uo_out              : current result byte (holds last byte when idle)
//   uio_out             : [1] out_stb, [3] fifo_full, [4] fifo_empty, [5] overflow
//   uio_oe              : constant 8'h3A
//   cmd_data/cmd_valid/cmd_ready : FIFO head toward the core
//   res_data/res_valid/res_ready : result word from the core
// Build option: define TINYSPU_LOOPBACK_EN to allow uio_in[7] to route the
// FIFO head straight into the serialiser instead of the core.
module tinyspu_pin_frontend
  import tinyspu_io_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        ui_in,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uo_out,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [DATA_W-1:0] cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_valid,
  output logic              res_ready
);

  // state | meaning
  // IDLE  | no word in flight, ready for a new result (uo_out holds last byte)
  // SHOW  | byte idx on uo_out, out_stb high, waiting for out_ack high
  // ACKLO | out_stb low, waiting for out_ack low before next byte or IDLE

  localparam int NB    = nb_of(DATA_W);
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  // ---------------- synchronisers and edge detect ----------------
  logic [SYNC_STAGES-1:0] stb_sync_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   stb_prev_q;
  logic                   stb_s, ack_s, stb_rise;

  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign stb_rise = stb_s && !stb_prev_q;

  // The edge history keeps running while ena is low, so a strobe edge that
  // happens while deselected is consumed and never captured later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_sync_q <= '0;
      ack_sync_q <= '0;
      stb_prev_q <= 1'b0;
    end else begin
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], uio_in[IN_STB]};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], uio_in[OUT_ACK]};
      stb_prev_q <= stb_s;
    end
  end

  // ---------------- byte assembly ----------------
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] push_word_q, push_word_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              push_pend_q, push_pend_d;
  logic              capture;

  assign capture = stb_rise && ena;

  always_comb begin
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    push_word_d = push_word_q;
    push_pend_d = push_pend_q;
    if (push_pend_q && ena) push_pend_d = 1'b0;
    if (capture) begin
      asm_d[8*int'(cnt_q) +: 8] = ui_in;
      if (cnt_q == LAST_IDX) begin
        cnt_d       = '0;
        push_word_d = asm_d;
        push_pend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q       <= '0;
      cnt_q       <= '0;
      push_word_q <= '0;
      push_pend_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      push_word_q <= push_word_d;
      push_pend_q <= push_pend_d;
    end
  end

  // ---------------- command FIFO ----------------
  logic              fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_ovf;
  logic              lb_pop;
  logic              lpbk_active;

  assign fifo_push = push_pend_q && ena;
  assign cmd_valid = !fifo_empty && !lpbk_active;
  assign cmd_data  = fifo_rdata;
  assign fifo_pop  = ena && ((cmd_valid && cmd_ready) || lb_pop);

  tinyspu_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fifo_push),
    .wdata_i    (push_word_q),
    .pop_i      (fifo_pop),
    .rdata_o    (fifo_rdata),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_ovf)
  );

  // ---------------- result serialiser ----------------
  ser_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
  logic [DATA_W-1:0] word_q, word_d;
  logic [7:0]        uo_q, uo_d;

  assign idx_nxt   = idx_q + IDX_W'(1);
  assign res_ready = (state_q == IDLE) && !lpbk_active;

  // uo_q is loaded on every entry to SHOW, so it equals word[8*idx+:8] there
  // and naturally holds the last byte once back in IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    uo_d    = uo_q;
    lb_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena) begin
`ifdef TINYSPU_LOOPBACK_EN
          if (lpbk_active) begin
            if (!fifo_empty) begin
              word_d  = fifo_rdata;
              uo_d    = fifo_rdata[7:0];
              idx_d   = '0;
              lb_pop  = 1'b1;
              state_d = SHOW;
            end
          end else if (res_valid) begin
`else
          if (res_valid) begin
`endif
            word_d  = res_data;
            uo_d    = res_data[7:0];
            idx_d   = '0;
            state_d = SHOW;
          end
        end
      end
      SHOW: begin
        if (ena && ack_s) state_d = ACKLO;
      end
      ACKLO: begin
        if (ena && !ack_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_nxt;
            uo_d    = word_q[8*int'(idx_nxt) +: 8];
            state_d = SHOW;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      uo_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      uo_q    <= uo_d;
    end
  end

  // ---------------- loopback select ----------------
`ifdef TINYSPU_LOOPBACK_EN
  logic [SYNC_STAGES-1:0] lpbk_sync_q;
  logic                   lpbk_q;
  logic                   unused_uio;

  // Mode is only sampled while idle so a word in flight is never split
  // between the core result and the FIFO head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lpbk_sync_q <= '0;
      lpbk_q      <= 1'b0;
    end else begin
      lpbk_sync_q <= {lpbk_sync_q[SYNC_STAGES-2:0], uio_in[LPBK]};
      if (ena && state_q == IDLE) lpbk_q <= lpbk_sync_q[SYNC_STAGES-1];
    end
  end

  assign lpbk_active = lpbk_q;
  assign unused_uio  = ^{uio_in[6:3], uio_in[1]};
`else
  logic unused_uio;

  assign lpbk_active = 1'b0;
  assign unused_uio  = ^{uio_in[7:3], uio_in[1]};
`endif

  // ---------------- pin outputs ----------------
  assign uo_out = uo_q;
  assign uio_oe = UIO_OE_VAL;

  always_comb begin
    uio_out          = 8'h00;
    uio_out[OUT_STB] = (state_q == SHOW);
    uio_out[FULL]    = fifo_full;
    uio_out[EMPTY]   = fifo_empty;
    uio_out[OVF]     = fifo_ovf;
  end

endmodule

// File: tb/tb_tinyspu_pin_frontend.sv
module tb_tinyspu_pin_frontend;

  localparam int DW = 16;
  localparam int NB = DW / 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic [7:0]    ui_in;
  logic [7:0]    uio_in;
  logic [7:0]    uo_out, uio_out, uio_oe;
  logic [DW-1:0] cmd_data;
  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] res_data;
  logic          res_valid, res_ready;

  logic in_stb, out_ack, lpbk;
  assign uio_in = {lpbk, 4'b0000, out_ack, 1'b0, in_stb};

  wire out_stb = uio_out[1];
  wire f_full  = uio_out[3];
  wire f_empty = uio_out[4];
  wire f_ovf   = uio_out[5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tinyspu_pin_frontend #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .ui_in     (ui_in),
    .uio_in    (uio_in),
    .uo_out    (uo_out),
    .uio_out   (uio_out),
    .uio_oe    (uio_oe),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  typedef struct {
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [DW-1:0] exp;
  } vec_t;

  logic [DW-1:0] model_q[$];
  logic          ovf_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return out_stb;
      1:       return res_ready;
      default: return cmd_valid;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input string name);
    int n = 0;
    while (pick(sel) !== val && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pick(sel) !== val) begin
      errors++;
      $display("FAIL %s: timed out, got %b required %b", name, pick(sel), val);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    ui_in  = b;
    in_stb = 1'b1;
    repeat (4) @(posedge clk);
    #1 in_stb = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = 0; i < NB; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pop_check(input logic [DW-1:0] exp, input string name);
    @(negedge clk);
    check({name, " cmd_valid"}, {31'd0, cmd_valid}, 32'd1);
    check({name, " cmd_data"}, {16'd0, cmd_data}, {16'd0, exp});
    @(posedge clk); #1 cmd_ready = 1'b1;
    @(posedge clk); #1 cmd_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_q.delete();
    ovf_m = 1'b0;
  endtask

  // Offers w to the core side and follows the handshake byte by byte.
  task automatic serialise_check(input logic [DW-1:0] w, input string name);
    @(posedge clk); #1;
    res_data  = w;
    res_valid = 1'b1;
    @(posedge clk); #1 res_valid = 1'b0;
    @(negedge clk);
    check({name, " stb 1cyc after accept"}, {31'd0, out_stb}, 32'd1);
    for (int i = 0; i < NB; i++) begin
      wait_for(0, 1'b1, {name, " stb high"});
      check({name, " byte"}, {24'd0, uo_out}, {24'd0, w[8*i +: 8]});
      check({name, " res_ready busy"}, {31'd0, res_ready}, 32'd0);
      out_ack = 1'b1;
      wait_for(0, 1'b0, {name, " stb low"});
      check({name, " res_ready in ack"}, {31'd0, res_ready}, 32'd0);
      out_ack = 1'b0;
    end
    wait_for(1, 1'b1, {name, " res_ready back"});
    check({name, " uo hold"}, {24'd0, uo_out}, {24'd0, w[8*(NB-1) +: 8]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{8'h34, 8'h12, 16'h1234};
    vecs[1] = '{8'h00, 8'hFF, 16'hFF00};
    vecs[2] = '{8'hA5, 8'h5A, 16'h5AA5};
    vecs[3] = '{8'hFF, 8'hFF, 16'hFFFF};

    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00;
    in_stb = 1'b0; out_ack = 1'b0; lpbk = 1'b0;
    cmd_ready = 1'b0; res_data = '0; res_valid = 1'b0;
    model_q.delete(); ovf_m = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset state
    @(negedge clk);
    check("rst uio_oe", {24'd0, uio_oe}, 32'h3A);
    check("rst uo_out", {24'd0, uo_out}, 32'h0);
    check("rst uio_out", {24'd0, uio_out}, 32'h10);
    check("rst cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst res_ready", {31'd0, res_ready}, 32'd1);

    // 2: single word, pop, empty one cycle after the pop
    send_byte(8'h34);
    send_byte(8'h12);
    pop_check(16'h1234, "t2");
    @(negedge clk);
    check("t2 empty after pop", {31'd0, f_empty}, 32'd1);

    // table of byte pairs
    for (int i = 0; i < 4; i++) begin
      send_byte(vecs[i].b0);
      send_byte(vecs[i].b1);
      pop_check(vecs[i].exp, $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d empty", i), {31'd0, f_empty}, 32'd1);
    end

    // 3: overfill
    for (int i = 1; i <= 5; i++) send_word(DW'(16'h1000 + i));
    @(negedge clk);
    check("t3 full", {31'd0, f_full}, 32'd1);
    check("t3 overflow", {31'd0, f_ovf}, 32'd1);
    for (int i = 1; i <= 4; i++) pop_check(DW'(16'h1000 + i), $sformatf("t3 pop%0d", i));
    @(negedge clk);
    check("t3 word5 absent", {31'd0, cmd_valid}, 32'd0);
    check("t3 ovf sticky", {31'd0, f_ovf}, 32'd1);

    // ena low: strobe edges are lost, byte counter untouched
    @(posedge clk); #1 ena = 1'b0;
    send_word(16'h2211);
    @(posedge clk); #1 ena = 1'b1;
    @(negedge clk);
    check("ena0 no push", {31'd0, cmd_valid}, 32'd0);
    send_word(16'h4433);
    pop_check(16'h4433, "ena1 word");

    // 5: reset mid-word
    send_byte(8'hAB);
    do_reset();
    @(negedge clk);
    check("t5 ovf cleared", {31'd0, f_ovf}, 32'd0);
    check("t5 empty", {31'd0, f_empty}, 32'd1);
    send_byte(8'h56);
    send_byte(8'h78);
    pop_check(16'h7856, "t5");

    // randomized FIFO traffic against a queue model
    for (int it = 0; it < 4; it++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        logic [DW-1:0] w;
        w = DW'($urandom);
        send_word(w);
        if (model_q.size() < DEPTH) model_q.push_back(w);
        else ovf_m = 1'b1;
      end
      @(negedge clk);
      check($sformatf("rnd%0d full", it), {31'd0, f_full}, {31'd0, model_q.size() == DEPTH});
      check($sformatf("rnd%0d ovf", it), {31'd0, f_ovf}, {31'd0, ovf_m});
      while (model_q.size() > 0) pop_check(model_q.pop_front(), $sformatf("rnd%0d pop", it));
      @(negedge clk);
      check($sformatf("rnd%0d empty", it), {31'd0, f_empty}, 32'd1);
    end

    // 4: serialiser
    serialise_check(16'hBEEF, "t4");
    for (int it = 0; it < 4; it++) serialise_check(DW'($urandom), $sformatf("ser%0d", it));

`ifdef TINYSPU_LOOPBACK_EN
    // 6: loopback
    @(posedge clk); #1 lpbk = 1'b1;
    repeat (5) @(negedge clk);
    check("t6 cmd_valid off", {31'd0, cmd_valid}, 32'd0);
    check("t6 res_ready off", {31'd0, res_ready}, 32'd0);
    send_word(16'hA55A);
    for (int i = 0; i < NB; i++) begin
      logic [15:0] lw;
      lw = 16'hA55A;
      wait_for(0, 1'b1, "t6 stb high");
      check("t6 byte", {24'd0, uo_out}, {24'd0, lw[8*i +: 8]});
      check("t6 cmd_valid", {31'd0, cmd_valid}, 32'd0);
      out_ack = 1'b1;
      wait_for(0, 1'b0, "t6 stb low");
      out_ack = 1'b0;
    end
    repeat (5) @(negedge clk);
    check("t6 fifo drained", {31'd0, f_empty}, 32'd1);
    check("t6 cmd_valid end", {31'd0, cmd_valid}, 32'd0);
    #1 lpbk = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
